// File: rtl/udp_recv.sv
// udp_recv: UDP header parser on the receive path, downstream of the IPv4 stage.
// Consumes the IP payload byte stream, captures source port, destination port
// and payload length from the 8-byte UDP header, and qualifies the UDP payload
// bytes (active/last) with zero latency. Trailing Ethernet padding is ignored.
//
// Optional feature: define UDP_PORT_FILTER_EN to accept only destination ports
// in [PORT_BASE, PORT_BASE+PORT_COUNT). Rejected packets still update the
// registered port outputs but never flag payload bytes active.
//
// Handshake: rx_enable is a qualifier, not a valid/ready pair. Every clock with
// rx_enable high carries one byte on data; there is no backpressure. active is
// high exactly when that byte is a UDP payload byte, last marks the final one.
// A packet whose payload ends without last must be treated as aborted.
module udp_recv #(
  parameter logic [15:0] PORT_BASE  = 16'd1024,
  parameter logic [15:0] PORT_COUNT = 16'd16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_enable,
  input  logic [7:0]  data,
  output logic        active,
  output logic        last,
  output logic [15:0] remote_port,
  output logic [15:0] to_port,
  output logic [15:0] payload_len
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // FSM state; kept as a named signal so checkers can bind to it directly.
  logic [1:0]  state;
  logic [15:0] byte_no;
  logic [15:0] temp_src;
  logic [15:0] temp_dst;
  logic [15:0] temp_len;
  // Set by reset so a packet already in flight when reset releases is skipped;
  // cleared by the first rx_enable low.
  logic        need_gap;
  logic        port_ok;
  logic        len_empty;

  // A UDP length of 8 or less carries no payload; smaller values are malformed
  // and must not wrap payload_len.
  assign len_empty = (temp_len <= 16'd8);

`ifdef UDP_PORT_FILTER_EN
  // Window compare done in 17 bits so PORT_BASE+PORT_COUNT cannot wrap.
  assign port_ok = ({1'b0, temp_dst} >= {1'b0, PORT_BASE}) &&
                   ({1'b0, temp_dst} <  ({1'b0, PORT_BASE} + {1'b0, PORT_COUNT}));
`else
  logic unused_filter_params;
  assign unused_filter_params = ^{PORT_BASE, PORT_COUNT};
  assign port_ok = 1'b1;
`endif

  // Payload qualifiers decode from state and rx_enable with no register stage.
  always_comb begin
    active = rx_enable && (state == ST_PAYLOAD);
    last   = active && (byte_no == payload_len);
  end

  // Header capture, byte counting and packet-phase sequencing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      byte_no     <= 16'd0;
      temp_src    <= 16'd0;
      temp_dst    <= 16'd0;
      temp_len    <= 16'd0;
      remote_port <= 16'd0;
      to_port     <= 16'd0;
      payload_len <= 16'd0;
      need_gap    <= 1'b1;
    end else if (!rx_enable) begin
      // Any gap ends the packet; registered header fields hold their values.
      state    <= ST_IDLE;
      byte_no  <= 16'd0;
      need_gap <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!need_gap) begin
            temp_src[15:8] <= data;
            byte_no        <= 16'd1;
            state          <= ST_HEADER;
          end
        end

        ST_HEADER: begin
          byte_no <= byte_no + 16'd1;
          case (byte_no)
            16'd1: temp_src[7:0]  <= data;
            16'd2: temp_dst[15:8] <= data;
            16'd3: temp_dst[7:0]  <= data;
            16'd4: temp_len[15:8] <= data;
            16'd5: temp_len[7:0]  <= data;
            16'd6: ; // checksum high byte, not verified
            16'd7: begin
              // Checksum low byte: publish the header so it is stable before
              // the first payload byte is flagged.
              remote_port <= temp_src;
              to_port     <= temp_dst;
              if (len_empty) begin
                payload_len <= 16'd0;
                state       <= ST_DONE;
              end else begin
                payload_len <= temp_len - 16'd8;
                byte_no     <= 16'd1;
                state       <= port_ok ? ST_PAYLOAD : ST_DONE;
              end
            end
            default: state <= ST_DONE;
          endcase
        end

        ST_PAYLOAD: begin
          byte_no <= byte_no + 16'd1;
          if (byte_no == payload_len) begin
            state <= ST_DONE;
          end
        end

        // Absorb padding and trailing bytes until the IP stage drops rx_enable.
        ST_DONE: state <= ST_DONE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_recv.sv
// tb_udp_recv: directed testbench for udp_recv. Drives byte streams on the
// falling edge, samples outputs mid-low-phase, and checks payload bytes against
// an expected queue plus hand-computed header fields.
module tb_udp_recv;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_enable = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        active;
  logic        last;
  logic [15:0] remote_port;
  logic [15:0] to_port;
  logic [15:0] payload_len;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pkt[$];
  logic [7:0]  exp_q[$];
  int          n_active;
  int          n_last;
  logic        last_final;
  logic [15:0] exp_to;
  int          exp_filt;

  // clock/reset block
  always #5 clock = ~clock;

  udp_recv #(.PORT_BASE(16'd1024), .PORT_COUNT(16'd16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_enable   (rx_enable),
    .data        (data),
    .active      (active),
    .last        (last),
    .remote_port (remote_port),
    .to_port     (to_port),
    .payload_len (payload_len)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic make_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    pkt.delete();
    exp_q.delete();
    pkt.push_back(src[15:8]); pkt.push_back(src[7:0]);
    pkt.push_back(dst[15:8]); pkt.push_back(dst[7:0]);
    pkt.push_back(len[15:8]); pkt.push_back(len[7:0]);
    pkt.push_back(8'h00);     pkt.push_back(8'h00);
    exp_to = dst;
  endtask

  task automatic push_pay(input logic [7:0] b);
    pkt.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic push_pad(input logic [7:0] b);
    pkt.push_back(b);
  endtask

  // Sends pkt with rx_enable held high; scoreboards every qualified byte.
  task automatic send_pkt();
    n_active   = 0;
    n_last     = 0;
    last_final = 1'b0;
    foreach (pkt[i]) begin
      @(negedge clock);
      rx_enable = 1'b1;
      data      = pkt[i];
      #2;
      if (active === 1'b1) begin
        n_active++;
        if (n_active == 1) check("to_port_at_first_payload", to_port, exp_to);
        if (exp_q.size() == 0) check("active_beyond_payload", active, 1'b0);
        else check("payload_byte", data, exp_q.pop_front());
        if (last === 1'b1) begin
          n_last++;
          last_final = (exp_q.size() == 0);
        end
      end else if (last === 1'b1) begin
        n_last++;
      end
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clock);
      rx_enable = 1'b0;
      data      = 8'h00;
    end
  endtask

  task automatic check_good(input string tag, input int n_pay);
    check({tag, "_active_count"}, n_active, n_pay);
    check({tag, "_last_count"}, n_last, 1);
    check({tag, "_last_on_final"}, last_final, 1'b1);
  endtask

  initial begin
`ifdef UDP_PORT_FILTER_EN
    exp_filt = 0;
`else
    exp_filt = 2;
`endif
    // Reset state
    #1;
    check("rst_active", active, 1'b0);
    check("rst_last", last, 1'b0);
    check("rst_remote_port", remote_port, 16'h0000);
    check("rst_to_port", to_port, 16'h0000);
    check("rst_payload_len", payload_len, 16'h0000);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    gap(2);

    // Normal packet with 6 pad bytes
    make_hdr(16'h0400, 16'h0401, 16'h000C);
    push_pay(8'hAA); push_pay(8'hBB); push_pay(8'hCC); push_pay(8'hDD);
    repeat (6) push_pad(8'h00);
    send_pkt();
    check_good("normal", 4);
    check("normal_remote_port", remote_port, 16'h0400);
    check("normal_to_port", to_port, 16'h0401);
    check("normal_payload_len", payload_len, 16'd4);
    gap(1);

    // Zero payload: length 8, then malformed length 5
    make_hdr(16'h0401, 16'h0402, 16'h0008);
    repeat (4) push_pad(8'h5A);
    send_pkt();
    check("len8_active_count", n_active, 0);
    check("len8_payload_len", payload_len, 16'd0);
    check("len8_to_port", to_port, 16'h0402);
    gap(1);
    make_hdr(16'h0402, 16'h0403, 16'h0005);
    repeat (4) push_pad(8'hA5);
    send_pkt();
    check("len5_active_count", n_active, 0);
    check("len5_payload_len", payload_len, 16'd0);
    gap(1);

    // Truncation: 8-byte payload announced, 3 delivered
    make_hdr(16'h0500, 16'h0402, 16'h0010);
    push_pay(8'h01); push_pay(8'h02); push_pay(8'h03);
    send_pkt();
    check("trunc_active_count", n_active, 3);
    check("trunc_last_count", n_last, 0);
    check("trunc_payload_len", payload_len, 16'd8);
    gap(1);
    make_hdr(16'h0501, 16'd1024, 16'h000A);
    push_pay(8'h11); push_pay(8'h22);
    send_pkt();
    check_good("after_trunc", 2);

    // Back-to-back with one idle cycle
    gap(1);
    make_hdr(16'h0600, 16'd1024, 16'h000A);
    push_pay(8'h31); push_pay(8'h32);
    send_pkt();
    check_good("b2b_first", 2);
    check("b2b_first_to_port", to_port, 16'd1024);
    gap(1);
    make_hdr(16'h0601, 16'd1025, 16'h000B);
    push_pay(8'h41); push_pay(8'h42); push_pay(8'h43);
    push_pad(8'hEE);
    send_pkt();
    check_good("b2b_second", 3);
    check("b2b_second_to_port", to_port, 16'd1025);
    check("b2b_second_remote", remote_port, 16'h0601);
    check("b2b_second_len", payload_len, 16'd3);
    gap(1);

    // Port window edges
    make_hdr(16'h0700, 16'd1039, 16'h000A);
    push_pay(8'h51); push_pay(8'h52);
    send_pkt();
    check("port1039_active_count", n_active, 2);
    gap(1);
    make_hdr(16'h0701, 16'd1040, 16'h000A);
    push_pay(8'h61); push_pay(8'h62);
    send_pkt();
    check("port1040_active_count", n_active, exp_filt);
    check("port1040_to_port", to_port, 16'd1040);
    gap(1);
    make_hdr(16'h0702, 16'd1023, 16'h000A);
    push_pay(8'h71); push_pay(8'h72);
    send_pkt();
    check("port1023_active_count", n_active, exp_filt);
    check("port1023_to_port", to_port, 16'd1023);
    gap(1);

    // Asynchronous reset mid-payload, released with rx_enable still high
    make_hdr(16'h0800, 16'h0405, 16'h000C);
    push_pay(8'hE1); push_pay(8'hE2);
    send_pkt();
    check("midrst_pre_active", n_active, 2);
    reset_n = 1'b0;
    #1;
    check("midrst_active", active, 1'b0);
    check("midrst_last", last, 1'b0);
    check("midrst_remote_port", remote_port, 16'h0000);
    check("midrst_to_port", to_port, 16'h0000);
    check("midrst_payload_len", payload_len, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    // Tail bytes shaped like a header: must not start a packet
    make_hdr(16'h0500, 16'h0501, 16'h000A);
    push_pad(8'h77); push_pad(8'h88);
    send_pkt();
    check("midrst_tail_active_count", n_active, 0);
    check("midrst_tail_to_port", to_port, 16'h0000);
    gap(1);
    make_hdr(16'h0900, 16'h0406, 16'h000A);
    push_pay(8'h9A); push_pay(8'h9B);
    send_pkt();
    check_good("post_rst", 2);
    check("post_rst_to_port", to_port, 16'h0406);
    gap(2);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
